// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit arbiter.
//   arb_state_e          : arbiter FSM states
//   UART_BYTE_W          : width of one transmitted byte
//   UART_ARB_TIMEOUT_DEF : default HOLD timeout in clock cycles
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_BYTE_W          = 8;
  localparam int UART_ARB_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_LOW,
    ST_WAIT_HIGH,
    ST_HOLD
  } arb_state_e;

endpackage

// File: rtl/rr_priority_select.sv
// ---------------------------------------------------------------------------
// rr_priority_select
// Combinational round-robin picker: returns the first set request at or
// above the start pointer, searching upward with wrap at N.
//   req_i  [N-1:0]  : request vector
//   ptr_i  [IW-1:0] : search start index (0..N-1)
//   gnt_o  [N-1:0]  : one-hot winner (zero when no request)
//   idx_o  [IW-1:0] : winner index
//   any_o           : at least one request present
// ---------------------------------------------------------------------------
module rr_priority_select #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int            j;
    logic [IW-1:0] jj;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      // Wrap explicitly at N; N need not be a power of two.
      j = int'(ptr_i) + i;
      if (j >= N) j = j - N;
      jj = IW'(j);
      if (!any_o && req_i[jj]) begin
        any_o     = 1'b1;
        gnt_o[jj] = 1'b1;
        idx_o     = jj;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin, packet-locked arbiter sharing one uart_drive transmit channel
// between P_REQ_NUM byte-stream requesters. Each byte is walked through the
// driver's level-ready handshake (valid pulse, ready falls, ready rises); the
// grant is held until the owner's last byte has left the driver.
//
// Optional feature macro: UART_ARB_TIMEOUT_EN
//   defined   : a HOLD counter force-releases a stalled packet after
//               P_TIMEOUT cycles and pulses o_timeout.
//   undefined : HOLD waits indefinitely, o_timeout is tied 0.
//
// Ports
//   i_clk, i_rst_n    : user clock, async active-low reset
//   i_req_data        : packed request bytes, requester k at [8k+7:8k]
//   i_req_valid/last  : per-requester byte valid / end-of-packet
//   o_req_ack         : one-cycle pulse when a requester's byte is taken
//   o_grant           : one-hot channel owner, zero when no packet active
//   o_uart_tx_data    : byte to the driver, stable until the next SEND
//   o_uart_tx_valid   : one-cycle pulse to the driver
//   i_uart_tx_ready   : driver idle (level)
//   o_busy            : FSM not in IDLE
//   o_timeout         : one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int P_REQ_NUM = 4,
  parameter int P_TIMEOUT = UART_ARB_TIMEOUT_DEF
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [P_REQ_NUM*UART_BYTE_W-1:0]   i_req_data,
  input  logic [P_REQ_NUM-1:0]               i_req_valid,
  input  logic [P_REQ_NUM-1:0]               i_req_last,
  output logic [P_REQ_NUM-1:0]               o_req_ack,
  output logic [P_REQ_NUM-1:0]               o_grant,
  output logic [UART_BYTE_W-1:0]             o_uart_tx_data,
  output logic                               o_uart_tx_valid,
  input  logic                               i_uart_tx_ready,
  output logic                               o_busy,
  output logic                               o_timeout
);

  localparam int IW = $clog2(P_REQ_NUM);

  if (P_REQ_NUM < 2 || P_REQ_NUM > 8) begin : g_bad_req_num
    $error("uart_tx_arbiter: P_REQ_NUM must be 2..8");
  end
  if (P_TIMEOUT < 2) begin : g_bad_timeout
    $error("uart_tx_arbiter: P_TIMEOUT must be >= 2");
  end

  logic [P_REQ_NUM-1:0][UART_BYTE_W-1:0] req_bytes;
  assign req_bytes = i_req_data;

  arb_state_e                 state_q;
  logic [IW-1:0]              ptr_q, idx_q, ptr_d;
  logic                       last_q;
  logic [UART_BYTE_W-1:0]     data_q;
  logic [P_REQ_NUM-1:0]       grant_q, ack_q;
  logic                       valid_q, busy_q;

  logic [P_REQ_NUM-1:0]       sel_gnt;
  logic [IW-1:0]              sel_idx;
  logic                       sel_any;

  rr_priority_select #(
    .N  (P_REQ_NUM),
    .IW (IW)
  ) u_sel (
    .req_i (i_req_valid),
    .ptr_i (ptr_q),
    .gnt_o (sel_gnt),
    .idx_o (sel_idx),
    .any_o (sel_any)
  );

  // Pointer after releasing owner idx_q; wraps at P_REQ_NUM, not 2**IW.
  assign ptr_d = (idx_q == IW'(P_REQ_NUM - 1)) ? '0 : idx_q + IW'(1);

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CW = $clog2(P_TIMEOUT);
  logic [CW-1:0] cnt_q;
  logic          timeout_q;
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      idx_q     <= '0;
      last_q    <= 1'b0;
      data_q    <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; set only on the transitions that fire them.
      ack_q   <= '0;
      valid_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (i_uart_tx_ready && sel_any) begin
            idx_q   <= sel_idx;
            data_q  <= req_bytes[sel_idx];
            last_q  <= i_req_last[sel_idx];
            grant_q <= sel_gnt;
            ack_q   <= sel_gnt;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: state_q <= ST_WAIT_LOW;
        // Ready low means the driver has latched the byte.
        ST_WAIT_LOW: if (!i_uart_tx_ready) state_q <= ST_WAIT_HIGH;
        ST_WAIT_HIGH: begin
          if (i_uart_tx_ready) begin
            if (last_q) begin
              grant_q <= '0;
              ptr_q   <= ptr_d;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
`ifdef UART_ARB_TIMEOUT_EN
              cnt_q   <= '0;
`endif
              state_q <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          // Only the owner is looked at; other valids wait for IDLE.
          if (i_req_valid[idx_q]) begin
            data_q  <= req_bytes[idx_q];
            last_q  <= i_req_last[idx_q];
            ack_q   <= grant_q;
            valid_q <= 1'b1;
            state_q <= ST_SEND;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (cnt_q == CW'(P_TIMEOUT - 1)) begin
            grant_q   <= '0;
            ptr_q     <= ptr_d;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= ST_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
`endif
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_req_ack       = ack_q;
  assign o_grant         = grant_q;
  assign o_uart_tx_data  = data_q;
  assign o_uart_tx_valid = valid_q;
  assign o_busy          = busy_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Bench for uart_tx_arbiter: requesters are byte queues, the driver is a
// ready-level model with random accept delay and frame time, and the
// expected byte order comes from a packet-level round-robin model.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [N*8-1:0]   req_data = '0;
  logic [N-1:0]     req_valid = '0, req_last = '0;
  logic [N-1:0]     req_ack, grant;
  logic [7:0]       tx_data;
  logic             tx_valid, busy, tmo;
  logic             tx_ready = 1'b1;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.P_REQ_NUM(N), .P_TIMEOUT(16)) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_req_data      (req_data),
    .i_req_valid     (req_valid),
    .i_req_last      (req_last),
    .o_req_ack       (req_ack),
    .o_grant         (grant),
    .o_uart_tx_data  (tx_data),
    .o_uart_tx_valid (tx_valid),
    .i_uart_tx_ready (tx_ready),
    .o_busy          (busy),
    .o_timeout       (tmo)
  );

  int vec = 0, mis = 0, cyc = 0;
  logic [7:0] rq_d [N][64];
  bit         rq_l [N][64];
  int         rq_h [N], rq_n [N];
  bit         pend [N];
  int         exp_idx[$];
  logic [7:0] exp_dat[$];
  int         m_ptr = 0;
  bit         drv_busy = 0;
  int         acc_cnt = 0, frame_cnt = 0, acc_force = -1;
  int         first_tx_cyc = -1, rise_cyc = 0, to_cyc = 0, to_count = 0, tx_count = 0;
  logic [N-1:0] grant_at_to;

  task automatic push_byte(input int k, input logic [7:0] d, input bit l);
    if (rq_h[k] == rq_n[k] && !pend[k]) begin rq_h[k] = 0; rq_n[k] = 0; end
    rq_d[k][rq_n[k]] = d;
    rq_l[k][rq_n[k]] = l;
    rq_n[k]++;
  endtask

  // Packet-level model: repeatedly pick the first pending requester at or
  // above the pointer, emit its whole packet, then move the pointer past it.
  task automatic build_expected();
    int h[N];
    int found;
    bit l;
    for (int k = 0; k < N; k++) h[k] = rq_h[k];
    forever begin
      found = -1;
      for (int i = 0; i < N; i++) begin
        int k = (m_ptr + i) % N;
        if (found < 0 && h[k] < rq_n[k]) found = k;
      end
      if (found < 0) break;
      do begin
        exp_idx.push_back(found);
        exp_dat.push_back(rq_d[found][h[found]]);
        l = rq_l[found][h[found]];
        h[found]++;
      end while (!l && h[found] < rq_n[found]);
      m_ptr = (found + 1) % N;
    end
  endtask

  task automatic clear_bench();
    for (int k = 0; k < N; k++) begin rq_h[k] = 0; rq_n[k] = 0; pend[k] = 0; end
    exp_idx.delete();
    exp_dat.delete();
    drv_busy = 0;
    tx_ready = 1'b1;
    req_valid = '0;
    req_last = '0;
    req_data = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_bench();
    m_ptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One clock: check outputs, advance the driver model, drive requesters.
  task automatic step();
    logic [N-1:0] oh;
    int ei;
    logic [7:0] ed;
    @(negedge clk);
    cyc++;
    if (tx_valid === 1'b1) begin
      tx_count++;
      if (first_tx_cyc < 0) first_tx_cyc = cyc;
      vec++;
      if (drv_busy) begin mis++; $display("FAIL tx_valid_while_driver_busy cyc=%0d", cyc); end
      if (exp_idx.size() == 0) begin
        vec++; mis++;
        $display("FAIL unexpected_byte got=%02h required=none", tx_data);
      end else begin
        ei = exp_idx.pop_front();
        ed = exp_dat.pop_front();
        oh = '0; oh[ei] = 1'b1;
        vec++;
        if (tx_data !== ed) begin mis++; $display("FAIL tx_data got=%02h required=%02h", tx_data, ed); end
        vec++;
        if (req_ack !== oh) begin mis++; $display("FAIL req_ack got=%b required=%b", req_ack, oh); end
        vec++;
        if (grant !== oh) begin mis++; $display("FAIL grant_at_send got=%b required=%b", grant, oh); end
      end
      drv_busy  = 1;
      acc_cnt   = (acc_force >= 0) ? acc_force : int'($urandom_range(0, 2));
      frame_cnt = int'($urandom_range(2, 5));
    end else begin
      vec++;
      if (req_ack !== '0) begin mis++; $display("FAIL ack_without_valid got=%b required=0", req_ack); end
      if (drv_busy) begin
        if (acc_cnt > 0) acc_cnt--;
        else if (tx_ready) tx_ready = 1'b0;
        else if (frame_cnt > 0) frame_cnt--;
        else begin tx_ready = 1'b1; drv_busy = 0; rise_cyc = cyc; end
      end
    end
    vec++;
    if (!$onehot0(grant)) begin mis++; $display("FAIL grant_onehot got=%b required=onehot0", grant); end
    if (tmo === 1'b1) begin to_count++; to_cyc = cyc; grant_at_to = grant; end
    for (int k = 0; k < N; k++) begin
      if (pend[k]) begin rq_h[k]++; pend[k] = 0; end
      if (req_ack[k] === 1'b1) pend[k] = 1;
      if (rq_h[k] < rq_n[k]) begin
        req_valid[k] = 1'b1;
        req_data[k*8 +: 8] = rq_d[k][rq_h[k]];
        req_last[k] = rq_l[k][rq_h[k]];
      end else begin
        req_valid[k] = 1'b0;
        req_data[k*8 +: 8] = 8'h00;
        req_last[k] = 1'b0;
      end
    end
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    bit done = 0;
    while (n < budget && !done) begin
      step();
      n++;
      done = (exp_idx.size() == 0) && !drv_busy && (busy === 1'b0);
      for (int k = 0; k < N; k++) if (rq_h[k] < rq_n[k] || pend[k]) done = 0;
    end
    vec++;
    if (!done) begin mis++; $display("FAIL run_budget got=%0d_cycles required=drained", n); end
    vec++;
    if (exp_idx.size() != 0) begin mis++; $display("FAIL missing_bytes got=%0d required=0", exp_idx.size()); end
    vec++;
    if (grant !== '0) begin mis++; $display("FAIL grant_after_run got=%b required=0", grant); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vec++; if (req_ack !== '0)   begin mis++; $display("FAIL rst_ack got=%b required=0", req_ack); end
    vec++; if (grant !== '0)     begin mis++; $display("FAIL rst_grant got=%b required=0", grant); end
    vec++; if (tx_data !== 8'h00) begin mis++; $display("FAIL rst_data got=%02h required=00", tx_data); end
    vec++; if (tx_valid !== 1'b0) begin mis++; $display("FAIL rst_valid got=%b required=0", tx_valid); end
    vec++; if (busy !== 1'b0)    begin mis++; $display("FAIL rst_busy got=%b required=0", busy); end
    vec++; if (tmo !== 1'b0)     begin mis++; $display("FAIL rst_timeout got=%b required=0", tmo); end
    do_reset();
  endtask

  task automatic test_single_byte();
    int t0;
    do_reset();
    first_tx_cyc = -1;
    push_byte(1, 8'hA5, 1);
    build_expected();
    step();
    t0 = cyc;
    step();
    vec++;
    if (first_tx_cyc !== t0 + 1) begin mis++; $display("FAIL idle_to_send_latency got=%0d required=%0d", first_tx_cyc, t0 + 1); end
    for (int i = 0; i < 50 && drv_busy; i++) begin
      step();
      if (drv_busy) begin
        vec++;
        if (grant !== 4'b0010) begin mis++; $display("FAIL grant_hold got=%b required=0010", grant); end
      end
    end
    step();
    vec++;
    if (grant !== 4'b0000) begin mis++; $display("FAIL grant_release got=%b required=0000", grant); end
    vec++;
    if (busy !== 1'b0) begin mis++; $display("FAIL busy_release got=%b required=0", busy); end
    // Pointer now 2: req2 must beat req0.
    push_byte(0, 8'h3C, 1);
    push_byte(2, 8'hC3, 1);
    build_expected();
    run_until_done(500);
  endtask

  task automatic test_simultaneous();
    do_reset();
    push_byte(0, 8'h10, 1);
    push_byte(2, 8'h20, 1);
    build_expected();
    run_until_done(500);
  endtask

  task automatic test_packet_lock();
    push_byte(3, 8'h11, 0);
    push_byte(3, 8'h22, 0);
    push_byte(3, 8'h33, 1);
    push_byte(0, 8'h44, 1);
    build_expected();
    run_until_done(800);
  endtask

  task automatic test_wrap();
    push_byte(3, 8'h5E, 1);
    build_expected();
    run_until_done(300);
    for (int k = 0; k < N; k++) push_byte(k, 8'h60 + 8'(k), 1);
    build_expected();
    run_until_done(800);
  endtask

  task automatic test_random();
    to_count = 0;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < N; k++) begin
        int np = int'($urandom_range(0, 2));
        for (int p = 0; p < np; p++) begin
          int len = int'($urandom_range(1, 3));
          for (int b = 0; b < len; b++) push_byte(k, 8'($urandom), (b == len - 1));
        end
      end
      build_expected();
      run_until_done(3000);
    end
    vec++;
    if (to_count != 0) begin mis++; $display("FAIL spurious_timeout got=%0d required=0", to_count); end
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int start, r;
    do_reset();
    to_count = 0;
    start = tx_count;
    push_byte(2, 8'h5A, 0);
    push_byte(3, 8'h77, 1);
    exp_idx.push_back(2); exp_dat.push_back(8'h5A);
    exp_idx.push_back(3); exp_dat.push_back(8'h77);
    m_ptr = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tx_count > start && !drv_busy) break;
    end
    r = rise_cyc;
    run_until_done(500);
    vec++;
    if (to_count != 1) begin mis++; $display("FAIL timeout_count got=%0d required=1", to_count); end
    vec++;
    if (to_cyc != r + 17) begin mis++; $display("FAIL timeout_cycle got=%0d required=%0d", to_cyc, r + 17); end
    vec++;
    if (grant_at_to !== '0) begin mis++; $display("FAIL timeout_grant got=%b required=0", grant_at_to); end
  endtask
`endif

  task automatic test_reset_mid();
    int start;
    do_reset();
    acc_force = 3;
    start = tx_count;
    push_byte(1, 8'hC3, 1);
    build_expected();
    for (int i = 0; i < 20 && tx_count == start; i++) step();
    step();
    rst_n = 1'b0;
    #1;
    vec++; if (grant !== '0)      begin mis++; $display("FAIL midrst_grant got=%b required=0", grant); end
    vec++; if (busy !== 1'b0)     begin mis++; $display("FAIL midrst_busy got=%b required=0", busy); end
    vec++; if (tx_data !== 8'h00) begin mis++; $display("FAIL midrst_data got=%02h required=00", tx_data); end
    vec++; if (tx_valid !== 1'b0) begin mis++; $display("FAIL midrst_valid got=%b required=0", tx_valid); end
    vec++; if (req_ack !== '0)    begin mis++; $display("FAIL midrst_ack got=%b required=0", req_ack); end
    clear_bench();
    m_ptr = 0;
    acc_force = -1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = N - 1; k >= 0; k--) push_byte(k, 8'h80 + 8'(k), 1);
    build_expected();
    run_until_done(800);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_simultaneous();
    test_packet_lock();
    test_wrap();
    test_random();
`ifdef UART_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin, packet-locked arbiter that shares the single transmit channel of `uart_drive` between `P_REQ_NUM` byte-stream requesters. It sits in the `w_user_clk` domain between the user logic (FIFO readers, status reporters, echo path) and `uart_drive`'s `i_user_tx_*`/`o_user_tx_ready` port. It sequences each byte through the driver's level-ready handshake. It holds the grant until the requester's last byte of a packet has fully left the driver.

## Interface
- `P_REQ_NUM`, 4: number of requesters, legal range 2..8.
- `P_TIMEOUT`, 1024: HOLD-state timeout in clock cycles. Used only with `UART_ARB_TIMEOUT_EN`.
- `i_clk`  in  1: user clock (`o_user_clk` of `uart_drive`).
- `i_rst_n`  in  1: asynchronous, active-low reset.
- `i_req_data`  in  P_REQ_NUM*8: packed bytes; requester k uses bits [8k+7:8k].
- `i_req_valid`  in  P_REQ_NUM: per-requester byte valid.
- `i_req_last`  in  P_REQ_NUM: marks the requester's current byte as the end of its packet.
- `o_req_ack`  out  P_REQ_NUM: one-cycle pulse when the byte is taken.
- `o_grant`  out  P_REQ_NUM: one-hot owner of the channel; all zero when no packet is active.
- `o_uart_tx_data`  out  8: drives `i_user_tx_data`.
- `o_uart_tx_valid`  out  1: one-cycle pulse; drives `i_user_tx_valid`.
- `i_uart_tx_ready`  in  1: `o_user_tx_ready`; high means the driver is idle.
- `o_busy`  out  1: high whenever state is not IDLE.
- `o_timeout`  out  1: one-cycle pulse when a packet is force-released. Tied 0 without the macro.

## Operation
Requester protocol:
- Assert valid, data and last, and hold them stable until the ack pulse.
- May drop valid or change data on the cycle after the ack.

States:
- **IDLE**
  - Condition: `i_uart_tx_ready`=1 and any `i_req_valid`.
  - Select a requester round-robin, searching upward from `r_ptr` with wrap.
  - Register its index, data and last, and set `o_grant`.
  - Next state: SEND.
  - If ready=0, stay in IDLE.
- **SEND** (one cycle)
  - `o_uart_tx_valid`=1.
  - `o_req_ack[g]`=1.
  - Next state: WAIT_LOW.
- **WAIT_LOW**
  - Wait for `i_uart_tx_ready`=0, meaning the driver has accepted the byte.
  - Then go to WAIT_HIGH.
- **WAIT_HIGH**
  - Wait for `i_uart_tx_ready`=1.
  - If the registered last=1: release the grant, set `r_ptr` to (g+1) mod P_REQ_NUM, go to IDLE.
  - Otherwise go to HOLD.
- **HOLD**
  - If `i_req_valid[g]`=1: register data and last, go to SEND.
  - Valids from other requesters are ignored while the grant is held.

Rules:
- A request is never interrupted mid-packet, apart from the timeout case in Configuration.
- Simultaneous requests in IDLE: the first set bit at or above `r_ptr` wins. After reset `r_ptr`=0.
- A single-byte packet is a byte with last=1.
- The index width is `$clog2(P_REQ_NUM)`. The pointer increment wraps explicitly at P_REQ_NUM, not at a power of two.
- Reset asserted at any time, including mid-byte:
  - State goes to IDLE and the grant clears.
  - `r_ptr` and the registered index, data and last return to 0.
  - The driver's own reset governs any frame in flight.

## Timing
- Reset values: `o_req_ack`=0, `o_grant`=0, `o_uart_tx_data`=8'h00, `o_uart_tx_valid`=0, `o_busy`=0, `o_timeout`=0.
- All outputs are registered.
- IDLE to SEND: `i_req_valid` sampled at edge t gives `o_uart_tx_valid` and `o_req_ack` high during cycle t+1.
- `o_uart_tx_data` is stable from cycle t+1 until the next SEND.
- HOLD to SEND takes 1 cycle from valid sampled.
- Byte-to-byte gap is the driver's frame time plus 2 cycles.
- `o_grant` is set from cycle t+1. It clears on the cycle after WAIT_HIGH sees ready with last=1.
- The next IDLE arbitration may occur on that same cycle.

## Configuration
- `UART_ARB_TIMEOUT_EN` defined:
  - A counter runs in HOLD and resets on entry to HOLD.
  - If it reaches P_TIMEOUT-1 with no valid from the owner, the packet is force-released: grant cleared, `r_ptr` advanced, `o_timeout` pulsed, state goes to IDLE.
  - This prevents a stalled requester from locking the UART.
- Undefined:
  - No counter is built; HOLD waits indefinitely.
  - `o_timeout` is constant 0.

## Structure
- Shared package `uart_pkg`:
  - State enum: IDLE, SEND, WAIT_LOW, WAIT_HIGH, HOLD.
  - `UART_BYTE_W`=8.
  - Default P_TIMEOUT constant.
- One sub-module, `rr_priority_select`: combinational; inputs request vector and start pointer; outputs one-hot grant, index and `any` flag.

## Test plan
- **Single byte, idle driver.** Req1 sends 8'hA5 with last=1 → `o_uart_tx_valid` 1 cycle later with data 8'hA5; `o_req_ack[1]` pulses once; grant 4'b0010 until ready returns; `r_ptr`=2.
- **Simultaneous requests, reset pointer.** Req0 and req2 both valid (1-byte packets) after reset → order 0 then 2; second SEND only after ready falls and rises.
- **Packet lock.** Req3 sends a 3-byte packet 8'h11, 8'h22, 8'h33 (last on 8'h33) while req0 stays valid → bytes leave in order 11, 22, 33; then req0 is served; req0 sees no ack during the packet.
- **Pointer wrap.** Last grant was index 3 with all requesters valid → next grant is index 0.
- **Timeout (macro on, P_TIMEOUT=16).** Req2 stalls after its first non-last byte → `o_timeout` pulses 16 cycles into HOLD; grant clears; req3 is served next.
- **Reset mid-operation.** `i_rst_n` low during WAIT_LOW → all outputs return to reset values immediately; after release, arbitration restarts at req0.
